// File: rtl/pipe_pkg.sv
// Shared decode-stage types: control bundle, NOP constant and default-width payload view.
package pipe_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_INSTRUCTION = 32;
   localparam int DEF_ALU_CONTROL = 4;
   localparam int DEF_REG_ADDR    = 5;

   // Every control bit that must be forced low on a bubble.
   typedef struct packed {
      logic       load;
      logic       store;
      logic       branch;
      logic       next_sel;
      logic       jalr;
      logic       branch_result;
      logic       mem_en;
      logic       reg_write;
      logic [1:0] mem_to_reg;
   } decode_ctrl_t;

   localparam decode_ctrl_t CTRL_NOP = '0;
   localparam int           CTRL_W   = $bits(decode_ctrl_t);

   // Full beat at the default widths; the stage itself packs a flat vector so
   // that it can be re-parametrised.
   typedef struct packed {
      logic [DEF_INSTRUCTION-1:0] instruction;
      logic [DEF_DATA_WIDTH-1:0]  pc;
      logic [DEF_ALU_CONTROL-1:0] alu_control;
      logic [DEF_DATA_WIDTH-1:0]  opa;
      logic [DEF_DATA_WIDTH-1:0]  opb;
      logic [DEF_REG_ADDR-1:0]    rs1;
      logic [DEF_REG_ADDR-1:0]    rs2;
      decode_ctrl_t               ctrl;
   } decode_payload_t;

endpackage

// File: rtl/decode_skid_slot.sv
// One-entry valid+payload holder; clear wins over load, load wins over unload.
module decode_skid_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic         unload_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Slot occupancy and captured payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (unload_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/decode_stage_reg.sv
// Decode->execute pipeline register with valid/ready, flush, bubble and stall counter.
// Optional one-entry skid slot (registered in_ready) enabled by DECODE_STAGE_SKID_EN.
module decode_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int INSTRUCTION = 32,
   parameter int ALU_CONTROL = 4,
   parameter int REG_ADDR    = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   flush,
   input  logic [INSTRUCTION-1:0] instruction,
   input  logic [DATA_WIDTH-1:0]  pc,
   input  logic [ALU_CONTROL-1:0] alu_control,
   input  logic [DATA_WIDTH-1:0]  opa_mux_out,
   input  logic [DATA_WIDTH-1:0]  opb_mux_out,
   input  logic [REG_ADDR-1:0]    rs1,
   input  logic [REG_ADDR-1:0]    rs2,
   input  logic                   Load,
   input  logic                   Store,
   input  logic                   Branch,
   input  logic                   next_sel,
   input  logic                   Jalr,
   input  logic                   branch_result,
   input  logic                   mem_en,
   input  logic                   reg_write,
   input  logic [1:0]             mem_to_reg,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTRUCTION-1:0] instruction_decode_pp,
   output logic [DATA_WIDTH-1:0]  pc_decode_pp,
   output logic [ALU_CONTROL-1:0] alu_control_decode_pp,
   output logic [DATA_WIDTH-1:0]  opa_mux_out_decode_pp,
   output logic [DATA_WIDTH-1:0]  opb_mux_out_decode_pp,
   output logic [REG_ADDR-1:0]    rs1_decode_pp,
   output logic [REG_ADDR-1:0]    rs2_decode_pp,
   output logic                   Load_decode_pp,
   output logic                   Store_decode_pp,
   output logic                   Branch_decode_pp,
   output logic                   next_sel_decode_pp,
   output logic                   Jalr_decode_pp,
   output logic                   branch_result_decode_pp,
   output logic                   mem_en_decode_pp,
   output logic                   reg_write_decode_pp,
   output logic [1:0]             mem_to_reg_decode_pp,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int PW = INSTRUCTION + 3*DATA_WIDTH + ALU_CONTROL + 2*REG_ADDR;
   localparam int BW = PW + CTRL_W;

   logic [PW-1:0]          in_data;
   decode_ctrl_t           in_ctrl;
   logic [BW-1:0]          main_src;
   logic                   main_load;
   logic                   xfer_in;
   logic                   xfer_out;
   logic                   valid_q;
   logic [PW-1:0]          data_q;
   decode_ctrl_t           ctrl_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   assign in_data = {instruction, pc, alu_control, opa_mux_out, opb_mux_out, rs1, rs2};

   // Gather the loose control inputs into the shared control bundle.
   always_comb begin
      in_ctrl               = CTRL_NOP;
      in_ctrl.load          = Load;
      in_ctrl.store         = Store;
      in_ctrl.branch        = Branch;
      in_ctrl.next_sel      = next_sel;
      in_ctrl.jalr          = Jalr;
      in_ctrl.branch_result = branch_result;
      in_ctrl.mem_en        = mem_en;
      in_ctrl.reg_write     = reg_write;
      in_ctrl.mem_to_reg    = mem_to_reg;
   end

   assign xfer_out = valid_q && out_ready;

`ifdef DECODE_STAGE_SKID_EN
   logic          skid_valid;
   logic [BW-1:0] skid_data;
   logic          skid_load;
   logic          skid_unload;

   // in_ready is purely the registered "skid empty" flag: no out_ready path.
   assign in_ready    = !skid_valid;
   assign xfer_in     = in_valid && !skid_valid;
   // A beat that cannot enter main (full and not draining) parks in the skid.
   assign skid_load   = xfer_in && valid_q && !out_ready;
   assign skid_unload = xfer_out && skid_valid;
   assign main_load   = skid_unload || (xfer_in && (!valid_q || out_ready));
   // The skid, when occupied, always holds the older beat, so it refills main first.
   assign main_src    = skid_valid ? skid_data : {in_data, in_ctrl};

   decode_skid_slot #(.W(BW)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (flush),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .data_i   ({in_data, in_ctrl}),
      .valid_o  (skid_valid),
      .data_o   (skid_data)
   );
`else
   assign in_ready  = !valid_q || out_ready;
   assign xfer_in   = in_valid && in_ready;
   assign main_load = xfer_in;
   assign main_src  = {in_data, in_ctrl};
`endif

   // Main register: flush beats load, load beats drain; controls are zeroed
   // whenever the stage goes empty so bubbles never carry side effects.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= CTRL_NOP;
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
      end else if (main_load) begin
         valid_q <= 1'b1;
         data_q  <= main_src[BW-1:CTRL_W];
         ctrl_q  <= main_src[CTRL_W-1:0];
      end else if (xfer_out) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
      end
   end

   assign stall_cnt_d = (valid_q && !out_ready && (stall_cnt_q != '1))
                        ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

   // Saturating back-pressure counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign out_valid = valid_q;
   assign stall_cnt = stall_cnt_q;
   assign {instruction_decode_pp, pc_decode_pp, alu_control_decode_pp,
           opa_mux_out_decode_pp, opb_mux_out_decode_pp,
           rs1_decode_pp, rs2_decode_pp} = data_q;
   assign Load_decode_pp          = ctrl_q.load;
   assign Store_decode_pp         = ctrl_q.store;
   assign Branch_decode_pp        = ctrl_q.branch;
   assign next_sel_decode_pp      = ctrl_q.next_sel;
   assign Jalr_decode_pp          = ctrl_q.jalr;
   assign branch_result_decode_pp = ctrl_q.branch_result;
   assign mem_en_decode_pp        = ctrl_q.mem_en;
   assign reg_write_decode_pp     = ctrl_q.reg_write;
   assign mem_to_reg_decode_pp    = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_decode_stage_reg.sv
// Scoreboard bench for decode_stage_reg: accepted beats queue up in a FIFO model
// whose capacity is 1 (plain) or 2 (DECODE_STAGE_SKID_EN); a negedge monitor
// compares every DUT output against the model each cycle.
module tb_decode_stage_reg;

   localparam int SCW     = 4;
   localparam int CNT_MAX = (1 << SCW) - 1;
`ifdef DECODE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  alu;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [9:0]  ctrl;  // Load,Store,Branch,next_sel,Jalr,branch_result,mem_en,reg_write,mem_to_reg[1:0]
   } beat_t;

   logic clk = 1'b0;
   logic rst, in_valid, flush, out_ready;
   beat_t cur;
   logic in_ready, out_valid;
   logic [31:0] instruction_pp, pc_pp, opa_pp, opb_pp;
   logic [3:0]  alu_pp;
   logic [4:0]  rs1_pp, rs2_pp;
   logic        load_pp, store_pp, branch_pp, nsel_pp, jalr_pp, bres_pp, memen_pp, regw_pp;
   logic [1:0]  m2r_pp;
   logic [SCW-1:0] stall_cnt;

   always #5 clk = ~clk;

   decode_stage_reg #(
      .DATA_WIDTH(32), .INSTRUCTION(32), .ALU_CONTROL(4), .REG_ADDR(5), .STALL_CNT_W(SCW)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .instruction(cur.instr), .pc(cur.pc), .alu_control(cur.alu),
      .opa_mux_out(cur.opa), .opb_mux_out(cur.opb), .rs1(cur.rs1), .rs2(cur.rs2),
      .Load(cur.ctrl[9]), .Store(cur.ctrl[8]), .Branch(cur.ctrl[7]), .next_sel(cur.ctrl[6]),
      .Jalr(cur.ctrl[5]), .branch_result(cur.ctrl[4]), .mem_en(cur.ctrl[3]),
      .reg_write(cur.ctrl[2]), .mem_to_reg(cur.ctrl[1:0]),
      .out_valid(out_valid), .out_ready(out_ready),
      .instruction_decode_pp(instruction_pp), .pc_decode_pp(pc_pp), .alu_control_decode_pp(alu_pp),
      .opa_mux_out_decode_pp(opa_pp), .opb_mux_out_decode_pp(opb_pp),
      .rs1_decode_pp(rs1_pp), .rs2_decode_pp(rs2_pp),
      .Load_decode_pp(load_pp), .Store_decode_pp(store_pp), .Branch_decode_pp(branch_pp),
      .next_sel_decode_pp(nsel_pp), .Jalr_decode_pp(jalr_pp), .branch_result_decode_pp(bres_pp),
      .mem_en_decode_pp(memen_pp), .reg_write_decode_pp(regw_pp), .mem_to_reg_decode_pp(m2r_pp),
      .stall_cnt(stall_cnt)
   );

   // ---------------- reference model ----------------
   beat_t exp_q[$];
   beat_t last_head;
   int    cnt_m;
   int    total = 0;
   int    bad   = 0;
   logic  check_en = 1'b0;
   logic  m_acc;

   function automatic logic model_in_ready();
`ifdef DECODE_STAGE_SKID_EN
      return exp_q.size() < CAP;
`else
      return (exp_q.size() < CAP) || out_ready;
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         cnt_m     = 0;
         last_head = '0;
      end else begin
         m_acc = in_valid && model_in_ready();
         if (exp_q.size() > 0 && !out_ready && cnt_m < CNT_MAX) cnt_m = cnt_m + 1;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (m_acc) exp_q.push_back(cur);
         end
         if (exp_q.size() > 0) last_head = exp_q[0];
      end
   end

   // ---------------- monitor ----------------
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         beat_t e;
         logic  ev;
         ev = exp_q.size() > 0;
         e  = ev ? exp_q[0] : last_head;
         if (!ev) e.ctrl = '0;
         chk("out_valid", 256'(out_valid), 256'(ev));
         chk("in_ready",  256'(in_ready),  256'(model_in_ready()));
         chk("data", 256'({instruction_pp, pc_pp, alu_pp, opa_pp, opb_pp, rs1_pp, rs2_pp}),
                     256'({e.instr, e.pc, e.alu, e.opa, e.opb, e.rs1, e.rs2}));
         chk("ctrl", 256'({load_pp, store_pp, branch_pp, nsel_pp, jalr_pp, bres_pp, memen_pp, regw_pp, m2r_pp}),
                     256'(e.ctrl));
         chk("stall_cnt", 256'(stall_cnt), 256'(cnt_m));
         if (ev && out_ready && !flush && !rst)
            $display("beat out pc=%08h ctrl=%03h", pc_pp, e.ctrl);
      end
   end

   // ---------------- stimulus ----------------
   function automatic beat_t rnd_beat(input logic [31:0] pcv);
      beat_t b;
      b.instr = $urandom; b.pc = pcv; b.alu = 4'($urandom);
      b.opa = $urandom; b.opb = $urandom;
      b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.ctrl = 10'($urandom);
      return b;
   endfunction

   task automatic drive(input logic iv, input beat_t b, input logic ordy, input logic fl);
      in_valid = iv; cur = b; out_ready = ordy; flush = fl;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b1, rnd_beat(32'hdead), 1'b1, 1'b0);
      drive(1'b1, rnd_beat(32'hbeef), 1'b0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      beat_t b;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; cur = '0;
      @(posedge clk); #1;
      check_en = 1'b1;
      do_reset();

      // Stream 0x0, 0x4, 0x8 with the sink always ready.
      for (int i = 0; i < 3; i++) drive(1'b1, rnd_beat(32'(i*4)), 1'b1, 1'b0);
      drive(1'b0, rnd_beat(32'h0), 1'b1, 1'b0);
      drive(1'b0, rnd_beat(32'h0), 1'b1, 1'b0);

      // Stall with pc=0x10 reg_write=1, then 0x14 offered while stalled.
      b = rnd_beat(32'h10); b.ctrl[2] = 1'b1;
      drive(1'b1, b, 1'b0, 1'b0);
      b = rnd_beat(32'h14);
      for (int i = 0; i < 4; i++) drive(1'b1, b, 1'b0, 1'b0);
      drive(1'b0, b, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, b, 1'b1, 1'b0);

      // Flush while holding 0x20 (mem_en=1) and offering 0x24.
      b = rnd_beat(32'h20); b.ctrl[3] = 1'b1; b.ctrl[2] = 1'b1;
      drive(1'b1, b, 1'b0, 1'b0);
      drive(1'b1, rnd_beat(32'h24), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b0, rnd_beat(32'h0), 1'b1, 1'b0);

      // Continuous input with out_ready toggling.
      for (int i = 0; i < 16; i++) drive(1'b1, rnd_beat(32'h100 + 32'(i*4)), 1'((i+1) % 2), 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, rnd_beat(32'h0), 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 250; i++)
         drive(1'(($urandom % 4) != 0), rnd_beat($urandom), 1'(($urandom % 3) != 0),
               1'(($urandom % 16) == 0));

      // Counter saturation from a clean start.
      do_reset();
      drive(1'b1, rnd_beat(32'h40), 1'b0, 1'b0);
      for (int i = 0; i < (1 << SCW) + 3; i++) drive(1'b0, rnd_beat(32'h0), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, rnd_beat(32'h0), 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
